// File: rtl/iob_fifo_sync_fwft.sv
// iob_fifo_sync_fwft
// ------------------
// Synchronous FIFO with asymmetric write/read widths. Storage is a register
// array of 2^ADDR_W slots, each min(W_DATA_W, R_DATA_W) bits wide. A wide word
// occupies N consecutive slots, with the least-significant chunk at the lowest
// address. With FWFT=0 read data is registered and loads one cycle after an
// accepted read. With FWFT=1 the head word is shown whenever the FIFO is not
// empty.
//
// Ports
//   clk_i, rst_i      clock (rising edge), synchronous active-high reset
//   cke_i             clock enable; low freezes all state (reset still acts)
//   w_en_i, w_data_i  write request and data; w_full_o means no room for a word
//   r_en_i, r_data_o  read request and data; r_empty_o means less than one word
//   afull_thr_i       almost-full threshold, in narrow-slot units
//   aempty_thr_i      almost-empty threshold, in narrow-slot units
//   almost_full_o     level_o >= afull_thr_i
//   almost_empty_o    level_o <= aempty_thr_i
//   overflow_o        sticky: a write was attempted while full
//   underflow_o       sticky: a read was attempted while empty
//   clr_err_i         clears both sticky flags
//   level_o           occupancy, in narrow-slot units
module iob_fifo_sync_fwft #(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 4,
    parameter int FWFT     = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,
    input  logic                w_en_i,
    input  logic [W_DATA_W-1:0] w_data_i,
    output logic                w_full_o,
    input  logic                r_en_i,
    output logic [R_DATA_W-1:0] r_data_o,
    output logic                r_empty_o,
    input  logic [ADDR_W:0]     afull_thr_i,
    input  logic [ADDR_W:0]     aempty_thr_i,
    output logic                almost_full_o,
    output logic                almost_empty_o,
    output logic                overflow_o,
    output logic                underflow_o,
    input  logic                clr_err_i,
    output logic [ADDR_W:0]     level_o
);

    localparam int MINDATA_W = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
    localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W;
    localparam int N         = MAXDATA_W / MINDATA_W;
    localparam int W_INCR    = (W_DATA_W > R_DATA_W) ? N : 1;
    localparam int R_INCR    = (R_DATA_W > W_DATA_W) ? N : 1;
    localparam int DEPTH     = 1 << ADDR_W;

    localparam logic [ADDR_W:0]   W_INCR_L   = (ADDR_W+1)'(W_INCR);
    localparam logic [ADDR_W:0]   R_INCR_L   = (ADDR_W+1)'(R_INCR);
    localparam logic [ADDR_W:0]   FULL_LIMIT = (ADDR_W+1)'(DEPTH - W_INCR);
    localparam logic [ADDR_W-1:0] W_INCR_A   = ADDR_W'(W_INCR);
    localparam logic [ADDR_W-1:0] R_INCR_A   = ADDR_W'(R_INCR);

    logic [ADDR_W-1:0]    wptr_q, wptr_d;
    logic [ADDR_W-1:0]    rptr_q, rptr_d;
    logic [ADDR_W:0]      level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic [MINDATA_W-1:0] mem_q [DEPTH];
    logic [MINDATA_W-1:0] mem_d [DEPTH];
    logic [R_DATA_W-1:0]  head_word;
    logic                 w_full, r_empty, w_acc, r_acc;

    // Status flags come straight from the registered level.
    assign w_full  = (level_q > FULL_LIMIT);
    assign r_empty = (level_q < R_INCR_L);
    assign w_acc   = w_en_i & ~w_full;
    assign r_acc   = r_en_i & ~r_empty;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q + (w_acc ? W_INCR_L : '0) - (r_acc ? R_INCR_L : '0);
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (w_acc) wptr_d = wptr_q + W_INCR_A;
        if (r_acc) rptr_d = rptr_q + R_INCR_A;
        // Clear first so that a new error in the same cycle wins.
        if (clr_err_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (w_en_i && w_full)  overflow_d  = 1'b1;
        if (r_en_i && r_empty) underflow_d = 1'b1;
    end

    // Scatter an accepted write word over W_INCR consecutive slots.
    always_comb begin
        mem_d = mem_q;
        if (w_acc) begin
            for (int i = 0; i < W_INCR; i++) begin
                mem_d[wptr_q + ADDR_W'(i)] = w_data_i[i*MINDATA_W +: MINDATA_W];
            end
        end
    end

    // Gather the word at the read pointer from R_INCR consecutive slots.
    always_comb begin
        head_word = '0;
        for (int i = 0; i < R_INCR; i++) begin
            head_word[i*MINDATA_W +: MINDATA_W] = mem_q[rptr_q + ADDR_W'(i)];
        end
    end

    // The array is never reset; a write presented during reset is dropped.
    always_ff @(posedge clk_i) begin
        if (cke_i && !rst_i) mem_q <= mem_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (cke_i) begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [R_DATA_W-1:0] r_data_q, r_data_d;

            always_comb begin
                r_data_d = r_data_q;
                if (r_acc) r_data_d = head_word;
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_data_q <= '0;
                end else if (cke_i) begin
                    r_data_q <= r_data_d;
                end
            end

            assign r_data_o = r_data_q;
        end else begin : g_fwft_read
            // Masked while empty so stale or partial slots never show.
            assign r_data_o = r_empty ? '0 : head_word;
        end
    endgenerate

    assign w_full_o       = w_full;
    assign r_empty_o      = r_empty;
    assign level_o        = level_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;
    assign almost_full_o  = (level_q >= afull_thr_i);
    assign almost_empty_o = (level_q <= aempty_thr_i);

endmodule

// File: tb/tb_iob_fifo_sync_fwft.sv
// tb_iob_fifo_sync_fwft
// ---------------------
// Three instances: dut 0 = defaults (32 -> 8, FWFT=0), dut 1 = 8 -> 32 (FWFT=0),
// dut 2 = 8 -> 8, ADDR_W=3, FWFT=1. A byte-queue model predicts every output
// and is compared on each falling edge; directed steps add literal checks.
module tb_iob_fifo_sync_fwft;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cke = 1'b1;
    logic clr = 1'b0;
    logic [4:0] afull_thr  = 5'd12;
    logic [4:0] aempty_thr = 5'd3;

    logic        w_en   [NDUT];
    logic        r_en   [NDUT];
    logic [31:0] w_data [NDUT];

    logic [7:0]  rd0;
    logic [31:0] rd1;
    logic [7:0]  rd2;
    logic [4:0]  lv0, lv1;
    logic [3:0]  lv2;
    logic        full_o [NDUT];
    logic        empty_o[NDUT];
    logic        af_o   [NDUT];
    logic        ae_o   [NDUT];
    logic        ov_o   [NDUT];
    logic        un_o   [NDUT];
    logic [31:0] rdata  [NDUT];
    logic [31:0] lvl    [NDUT];

    assign rdata[0] = {24'd0, rd0};
    assign rdata[1] = rd1;
    assign rdata[2] = {24'd0, rd2};
    assign lvl[0]   = {27'd0, lv0};
    assign lvl[1]   = {27'd0, lv1};
    assign lvl[2]   = {28'd0, lv2};

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    iob_fifo_sync_fwft u_dut0 (
        .clk_i(clk), .rst_i(rst), .cke_i(cke),
        .w_en_i(w_en[0]), .w_data_i(w_data[0]), .w_full_o(full_o[0]),
        .r_en_i(r_en[0]), .r_data_o(rd0), .r_empty_o(empty_o[0]),
        .afull_thr_i(afull_thr), .aempty_thr_i(aempty_thr),
        .almost_full_o(af_o[0]), .almost_empty_o(ae_o[0]),
        .overflow_o(ov_o[0]), .underflow_o(un_o[0]),
        .clr_err_i(clr), .level_o(lv0)
    );

    iob_fifo_sync_fwft #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4), .FWFT(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .cke_i(cke),
        .w_en_i(w_en[1]), .w_data_i(w_data[1][7:0]), .w_full_o(full_o[1]),
        .r_en_i(r_en[1]), .r_data_o(rd1), .r_empty_o(empty_o[1]),
        .afull_thr_i(afull_thr), .aempty_thr_i(aempty_thr),
        .almost_full_o(af_o[1]), .almost_empty_o(ae_o[1]),
        .overflow_o(ov_o[1]), .underflow_o(un_o[1]),
        .clr_err_i(clr), .level_o(lv1)
    );

    iob_fifo_sync_fwft #(.W_DATA_W(8), .R_DATA_W(8), .ADDR_W(3), .FWFT(1)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .cke_i(cke),
        .w_en_i(w_en[2]), .w_data_i(w_data[2][7:0]), .w_full_o(full_o[2]),
        .r_en_i(r_en[2]), .r_data_o(rd2), .r_empty_o(empty_o[2]),
        .afull_thr_i(afull_thr[3:0]), .aempty_thr_i(aempty_thr[3:0]),
        .almost_full_o(af_o[2]), .almost_empty_o(ae_o[2]),
        .overflow_o(ov_o[2]), .underflow_o(un_o[2]),
        .clr_err_i(clr), .level_o(lv2)
    );

    // Model: per instance, the stored bytes in order, oldest first.
    int win  [NDUT] = '{4, 1, 1};
    int rin  [NDUT] = '{1, 4, 1};
    int cap  [NDUT] = '{16, 16, 8};
    int fwft [NDUT] = '{0, 0, 1};
    logic [7:0]  mq      [NDUT][$];
    logic [31:0] m_rdata [NDUT];
    bit          m_ov    [NDUT];
    bit          m_un    [NDUT];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int n;
        bit m_full, m_empty;
        logic [31:0] word;
        for (int d = 0; d < NDUT; d++) begin
            n = mq[d].size();
            if (rst) begin
                mq[d].delete();
                m_rdata[d] = 32'd0;
                m_ov[d] = 1'b0;
                m_un[d] = 1'b0;
            end else if (cke) begin
                m_empty = (n < rin[d]);
                m_full  = (n > cap[d] - win[d]);
                if (w_en[d] && m_full) m_ov[d] = 1'b1;
                else if (clr)          m_ov[d] = 1'b0;
                if (r_en[d] && m_empty) m_un[d] = 1'b1;
                else if (clr)           m_un[d] = 1'b0;
                if (r_en[d] && !m_empty) begin
                    word = 32'd0;
                    for (int i = 0; i < rin[d]; i++) word[8*i +: 8] = mq[d].pop_front();
                    if (fwft[d] == 0) m_rdata[d] = word;
                end
                if (w_en[d] && !m_full) begin
                    for (int i = 0; i < win[d]; i++) mq[d].push_back(w_data[d][8*i +: 8]);
                end
            end
        end
    end

    always @(negedge clk) begin
        int n, athr, ethr;
        logic [31:0] exp_rd;
        if (checking) begin
            for (int d = 0; d < NDUT; d++) begin
                n    = mq[d].size();
                athr = (d == 2) ? int'(afull_thr[3:0])  : int'(afull_thr);
                ethr = (d == 2) ? int'(aempty_thr[3:0]) : int'(aempty_thr);
                if (fwft[d] != 0) begin
                    exp_rd = 32'd0;
                    if (n >= rin[d]) for (int i = 0; i < rin[d]; i++) exp_rd[8*i +: 8] = mq[d][i];
                end else begin
                    exp_rd = m_rdata[d];
                end
                checkOutput($sformatf("d%0d.level", d), lvl[d], 32'(n));
                checkOutput($sformatf("d%0d.empty", d), 32'(empty_o[d]), 32'(n < rin[d]));
                checkOutput($sformatf("d%0d.full", d), 32'(full_o[d]), 32'(n > cap[d] - win[d]));
                checkOutput($sformatf("d%0d.afull", d), 32'(af_o[d]), 32'(n >= athr));
                checkOutput($sformatf("d%0d.aempty", d), 32'(ae_o[d]), 32'(n <= ethr));
                checkOutput($sformatf("d%0d.overflow", d), 32'(ov_o[d]), 32'(m_ov[d]));
                checkOutput($sformatf("d%0d.underflow", d), 32'(un_o[d]), 32'(m_un[d]));
                checkOutput($sformatf("d%0d.rdata", d), rdata[d], exp_rd);
            end
        end
    end

    // One clock of stimulus on instance d; returns #2 after the edge.
    task automatic applyStimulus(input int d, input bit we, input logic [31:0] wd, input bit re);
        w_en[d]   = we;
        w_data[d] = wd;
        r_en[d]   = re;
        @(posedge clk);
        #2;
        w_en[d] = 1'b0;
        r_en[d] = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_bytes [4];
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int d = 0; d < NDUT; d++) begin
            w_en[d] = 1'b0;
            r_en[d] = 1'b0;
            w_data[d] = 32'd0;
        end
        @(posedge clk);
        #2;
        checking = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Reset state
        checkOutput("rst.level", lvl[0], 32'd0);
        checkOutput("rst.empty", 32'(empty_o[0]), 32'd1);
        checkOutput("rst.full", 32'(full_o[0]), 32'd0);
        checkOutput("rst.rdata", rdata[0], 32'd0);
        checkOutput("rst.rdata_fwft", rdata[2], 32'd0);

        // 32 -> 8: one word becomes four bytes, LSB first
        applyStimulus(0, 1'b1, 32'h44332211, 1'b0);
        checkOutput("w32.level", lvl[0], 32'd4);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1'b0, 32'd0, 1'b1);
            checkOutput($sformatf("w32.byte%0d", k), rdata[0], 32'(exp_bytes[k]));
        end
        checkOutput("w32.empty", 32'(empty_o[0]), 32'd1);
        applyStimulus(0, 1'b0, 32'd0, 1'b0);
        checkOutput("w32.hold", rdata[0], 32'h44);

        // Fill, then overflow and clear
        for (int k = 0; k < 4; k++) applyStimulus(0, 1'b1, {4{8'(k + 1)}}, 1'b0);
        checkOutput("fill.level", lvl[0], 32'd16);
        checkOutput("fill.full", 32'(full_o[0]), 32'd1);
        applyStimulus(0, 1'b1, 32'hFFFFFFFF, 1'b0);
        checkOutput("ovf.level", lvl[0], 32'd16);
        checkOutput("ovf.flag", 32'(ov_o[0]), 32'd1);
        applyStimulus(0, 1'b0, 32'd0, 1'b0);
        checkOutput("ovf.sticky", 32'(ov_o[0]), 32'd1);
        clr = 1'b1;
        applyStimulus(0, 1'b0, 32'd0, 1'b0);
        clr = 1'b0;
        checkOutput("ovf.clr", 32'(ov_o[0]), 32'd0);

        // Clock enable low freezes a read
        cke = 1'b0;
        applyStimulus(0, 1'b0, 32'd0, 1'b1);
        cke = 1'b1;
        checkOutput("cke.level", lvl[0], 32'd16);
        checkOutput("cke.rdata", rdata[0], 32'h44);

        // Threshold boundaries while draining
        for (int k = 0; k < 4; k++) applyStimulus(0, 1'b0, 32'd0, 1'b1);
        checkOutput("thr.afull12", 32'(af_o[0]), 32'd1);
        checkOutput("thr.rd_fourth", rdata[0], 32'h01);
        applyStimulus(0, 1'b0, 32'd0, 1'b1);
        checkOutput("thr.afull11", 32'(af_o[0]), 32'd0);
        for (int k = 0; k < 7; k++) applyStimulus(0, 1'b0, 32'd0, 1'b1);
        checkOutput("thr.aempty4", 32'(ae_o[0]), 32'd0);
        applyStimulus(0, 1'b0, 32'd0, 1'b1);
        checkOutput("thr.aempty3", 32'(ae_o[0]), 32'd1);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1'b0, 32'd0, 1'b1);
        checkOutput("drain.rdata", rdata[0], 32'h04);

        // Underflow, set beats clear
        applyStimulus(0, 1'b0, 32'd0, 1'b1);
        checkOutput("unf.flag", 32'(un_o[0]), 32'd1);
        checkOutput("unf.level", lvl[0], 32'd0);
        clr = 1'b1;
        applyStimulus(0, 1'b0, 32'd0, 1'b1);
        checkOutput("unf.set_wins", 32'(un_o[0]), 32'd1);
        applyStimulus(0, 1'b0, 32'd0, 1'b0);
        clr = 1'b0;
        checkOutput("unf.clr", 32'(un_o[0]), 32'd0);
        applyStimulus(0, 1'b0, 32'd0, 1'b1);

        // Simultaneous read and write: +4 -1
        applyStimulus(0, 1'b1, 32'hA3A2A1A0, 1'b0);
        applyStimulus(0, 1'b1, 32'hB3B2B1B0, 1'b1);
        checkOutput("rw.level", lvl[0], 32'd7);
        checkOutput("rw.rdata", rdata[0], 32'hA0);

        // Reset mid-fill with cke low and requests pending
        rst = 1'b1;
        cke = 1'b0;
        applyStimulus(0, 1'b1, 32'hDEADBEEF, 1'b1);
        rst = 1'b0;
        cke = 1'b1;
        checkOutput("rst2.level", lvl[0], 32'd0);
        checkOutput("rst2.empty", 32'(empty_o[0]), 32'd1);
        checkOutput("rst2.underflow", 32'(un_o[0]), 32'd0);
        checkOutput("rst2.rdata", rdata[0], 32'd0);

        // 8 -> 32: four bytes make one word
        applyStimulus(1, 1'b1, 32'hAA, 1'b0);
        applyStimulus(1, 1'b1, 32'hBB, 1'b0);
        applyStimulus(1, 1'b1, 32'hCC, 1'b0);
        checkOutput("w8.empty3", 32'(empty_o[1]), 32'd1);
        applyStimulus(1, 1'b1, 32'hDD, 1'b0);
        checkOutput("w8.empty4", 32'(empty_o[1]), 32'd0);
        applyStimulus(1, 1'b0, 32'd0, 1'b1);
        checkOutput("w8.rdata", rdata[1], 32'hDDCCBBAA);
        for (int k = 0; k < 16; k++) applyStimulus(1, 1'b1, 32'(k + 1), 1'b0);
        checkOutput("w8.full", 32'(full_o[1]), 32'd1);
        applyStimulus(1, 1'b1, 32'h77, 1'b0);
        checkOutput("w8.ovf", 32'(ov_o[1]), 32'd1);
        applyStimulus(1, 1'b0, 32'd0, 1'b1);
        checkOutput("w8.level12", lvl[1], 32'd12);
        checkOutput("w8.rdata2", rdata[1], 32'h04030201);

        // FWFT: no bypass into an empty FIFO, then fall-through
        applyStimulus(2, 1'b1, 32'h11, 1'b1);
        checkOutput("ft.nobypass_unf", 32'(un_o[2]), 32'd1);
        checkOutput("ft.nobypass_level", lvl[2], 32'd1);
        checkOutput("ft.nobypass_data", rdata[2], 32'h11);
        clr = 1'b1;
        applyStimulus(2, 1'b0, 32'd0, 1'b1);
        clr = 1'b0;
        checkOutput("ft.empty_data", rdata[2], 32'd0);
        applyStimulus(2, 1'b1, 32'h5A, 1'b0);
        checkOutput("ft.fall", rdata[2], 32'h5A);
        applyStimulus(2, 1'b1, 32'h6B, 1'b0);
        applyStimulus(2, 1'b1, 32'h7C, 1'b0);
        applyStimulus(2, 1'b1, 32'h8D, 1'b1);
        checkOutput("ft.rw_level", lvl[2], 32'd3);
        checkOutput("ft.rw_data", rdata[2], 32'h6B);
        for (int k = 0; k < 5; k++) applyStimulus(2, 1'b1, 32'(k + 8'h90), 1'b0);
        checkOutput("ft.full", 32'(full_o[2]), 32'd1);
        checkOutput("ft.full_level", lvl[2], 32'd8);

        applyStimulus(0, 1'b0, 32'd0, 1'b0);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iob_fifo_sync_fwft.md
IOB_FIFO_SYNC_FWFT -- requirements
Module: iob_fifo_sync_fwft

Interface
REQ-001 SHALL have parameter W_DATA_W, default 32, write word width in bits.
REQ-002 SHALL have parameter R_DATA_W, default 8, read word width in bits; max(W_DATA_W,R_DATA_W)/min(...) = N, a power of 2.
REQ-003 SHALL have parameter ADDR_W, default 4, log2 of capacity in MINDATA_W units; ADDR_W >= log2(N)+1.
REQ-004 SHALL have parameter FWFT, default 0; 0 = registered read data, 1 = first-word-fall-through.
REQ-005 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port cke_i  input  1  clock enable; 0 freezes all state.
REQ-008 SHALL have port w_en_i  input  1  write request.
REQ-009 SHALL have port w_data_i  input  W_DATA_W  write data.
REQ-010 SHALL have port w_full_o  output  1  no room for one write word.
REQ-011 SHALL have port r_en_i  input  1  read request.
REQ-012 SHALL have port r_data_o  output  R_DATA_W  read data.
REQ-013 SHALL have port r_empty_o  output  1  less than one read word stored.
REQ-014 SHALL have port afull_thr_i / aempty_thr_i  input  ADDR_W+1 each  programmable thresholds, MINDATA_W units.
REQ-015 SHALL have port almost_full_o / almost_empty_o  output  1 each  threshold flags.
REQ-016 SHALL have port overflow_o / underflow_o  output  1 each  sticky error flags.
REQ-017 SHALL have port clr_err_i  input  1  clears sticky error flags.
REQ-018 SHALL have port level_o  output  ADDR_W+1  occupancy, MINDATA_W units.

Function
REQ-019 SHALL store data internally in a 2^ADDR_W x MINDATA_W register array; no external memory port.
REQ-020 SHALL set W_INCR = N if W_DATA_W > R_DATA_W else 1; R_INCR = N if R_DATA_W > W_DATA_W else 1.
REQ-021 SHALL accept a write only when w_en_i=1 and w_full_o=0; a read only when r_en_i=1 and r_empty_o=0.
REQ-022 SHALL map a wide word to N consecutive narrow slots, least-significant chunk at lowest address (read and write).
REQ-023 SHALL advance write/read pointers by W_INCR/R_INCR per accepted op, wrapping modulo 2^ADDR_W.
REQ-024 SHALL update level_o next cycle: +W_INCR on write, -R_INCR on read, +W_INCR-R_INCR on both.
REQ-025 SHALL drive r_empty_o = (level_o < R_INCR), w_full_o = (level_o > 2^ADDR_W - W_INCR), from registered level.
REQ-026 SHALL drive almost_full_o = (level_o >= afull_thr_i), almost_empty_o = (level_o <= aempty_thr_i), combinationally.
REQ-027 SHALL, with FWFT=0, load r_data_o on the cycle after an accepted read and hold it otherwise.
REQ-028 SHALL, with FWFT=1, present the head word on r_data_o whenever r_empty_o=0; accepted read pops it, next word visible next cycle.
REQ-029 SHALL not make a write visible to the read side before the cycle after it is accepted (no same-cycle bypass).
REQ-030 SHALL set overflow_o on w_en_i=1 with w_full_o=0 false, underflow_o on r_en_i=1 with r_empty_o=1; hold until clr_err_i or rst_i.
REQ-031 SHALL give a set event priority over clr_err_i in the same cycle.
REQ-032 SHALL ignore rejected requests for pointers, level and data.
REQ-033 SHALL hold all state when cke_i=0, except rst_i.

Reset
REQ-034 SHALL, on rst_i=1 at a clock edge, regardless of cke_i, clear pointers, level_o=0, r_empty_o=1, w_full_o=0, overflow_o=0, underflow_o=0, r_data_o=0.
REQ-035 SHALL discard in-flight requests in the reset cycle; array contents need not be cleared.

Verification
REQ-036 Defaults, write 0x44332211 -> level_o=4, then 4 reads yield 0x11,0x22,0x33,0x44 (FWFT=0: one cycle after each read), r_empty_o=1.
REQ-037 Defaults, 4 writes -> level_o=16, w_full_o=1; 5th write -> level unchanged, overflow_o=1 until clr_err_i.
REQ-038 W_DATA_W=8, R_DATA_W=32, write 0xAA,0xBB,0xCC -> r_empty_o=1; 4th 0xDD -> r_empty_o=0, read yields 0xDDCCBBAA.
REQ-039 FWFT=1, 8/8, ADDR_W=3: write 0x5A -> next cycle r_data_o=0x5A without r_en_i; simultaneous read+write at level 3 -> level stays 3.
REQ-040 afull_thr_i=12, aempty_thr_i=3, defaults: level 12 -> almost_full_o=1; level 3 -> almost_empty_o=1; underflow on read when empty; rst_i mid-fill -> all REQ-034 values next cycle.
